bru_predictor: RTL and testbench

- Parametrised successor to the combinational branch resolution unit.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters and a tagged branch target buffer (BTB) for fetch-stage prediction.
- Keeps EX-stage resolution, with a registered resolve/mispredict output and table training.
- Sits between IF (lookup port) and EX/MEM (resolve port); the hazard unit consumes Mispredict/RedirectPc to flush.

---
 rtl/bru_predictor_pkg.sv | 26 ++
 rtl/bru_btb.sv | 63 ++++++
 rtl/bru_predictor.sv | 174 +++++++++++++++++
 tb/tb_bru_predictor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_predictor_pkg.sv
// Shared definitions for the branch resolution / prediction unit:
// BRU operation encodings, BHT counter constants and the saturating update.
package bru_predictor_pkg;

  typedef enum logic [2:0] {
    BRU_EQ  = 3'd0,
    BRU_NE  = 3'd1,
    BRU_LT  = 3'd2,
    BRU_GE  = 3'd3,
    BRU_LTU = 3'd4,
    BRU_GEU = 3'd5,
    BRU_JMP = 3'd6
  } bru_op_e;

  localparam logic [1:0] BHT_WNT  = 2'b01;
  localparam logic [1:0] CTR_MIN  = 2'b00;
  localparam logic [1:0] CTR_MAX  = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    end
    return (ctr == CTR_MIN) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bru_btb.sv
// Direct-mapped, tagged branch target buffer: combinational lookup with
// tag compare, one synchronous write port (read-before-write on collision).
module bru_btb
  import bru_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic            rd_jump_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [XLEN-1:0] wr_target_i,
  input  logic            wr_jump_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic               jump_q   [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             unused_pc_bits;

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign rd_tag = rd_pc_i[XLEN-1:IDX_W+2];
  assign wr_idx = wr_pc_i[IDX_W+1:2];
  assign wr_tag = wr_pc_i[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_jump_o   = jump_q[rd_idx];
  assign rd_target_o = target_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // NOTE: payload arrays are deliberately not reset; valid_q alone decides
  // whether an entry is meaningful, so these can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
      jump_q[wr_idx]   <= wr_jump_i;
    end
  end

endmodule

// File: rtl/bru_predictor.sv
// Branch resolution unit with BHT/BTB fetch prediction and registered resolve.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module bru_predictor
  import bru_predictor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] FetchPc,
  output logic            PredTaken,
  output logic [XLEN-1:0] PredPc,
  input  logic            ResValid,
  input  logic            Flush,
  input  logic [2:0]      BRUOp,
  input  logic            IsJalr,
  input  logic [XLEN-1:0] Rs1Data,
  input  logic [XLEN-1:0] Rs2Data,
  input  logic [XLEN-1:0] Pc,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] PredPcIn,
  output logic            OutValid,
  output logic            BranchTaken,
  output logic [XLEN-1:0] RedirectPc,
`ifdef BRU_PERF_CNT_EN
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount,
`endif
  output logic            Mispredict
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0] ctr_q [BHT_ENTRIES];

  logic [BHT_IDX_W-1:0] fetch_bht_idx;
  logic [BHT_IDX_W-1:0] res_bht_idx;
  logic                 btb_hit;
  logic                 btb_jump;
  logic [XLEN-1:0]      btb_target;

  logic            act;
  logic            op_valid;
  logic            op_is_jmp;
  logic            res_taken;
  logic            train;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] actual_pc;
  logic            res_mispred;

  logic            out_valid_q, out_valid_d;
  logic            taken_q,     taken_d;
  logic [XLEN-1:0] redirect_q,  redirect_d;
  logic            mispred_q,   mispred_d;

  // ---------------------------------------------------------------- lookup
  assign fetch_bht_idx = FetchPc[BHT_IDX_W+1:2];
  assign res_bht_idx   = Pc[BHT_IDX_W+1:2];

  bru_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (FetchPc),
    .rd_hit_o    (btb_hit),
    .rd_jump_o   (btb_jump),
    .rd_target_o (btb_target),
    .wr_en_i     (train && res_taken),
    .wr_pc_i     (Pc),
    .wr_target_i (target_pc),
    .wr_jump_i   (op_is_jmp)
  );

  assign PredTaken = btb_hit && (btb_jump || ctr_q[fetch_bht_idx][1]);
  assign PredPc    = PredTaken ? btb_target : FetchPc + XLEN'(4);

  // --------------------------------------------------------------- resolve
  // NOTE: every always_comb output gets a default before the case, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    res_taken = 1'b0;
    op_valid  = 1'b1;
    case (bru_op_e'(BRUOp))
      BRU_EQ:  res_taken = (Rs1Data == Rs2Data);
      BRU_NE:  res_taken = (Rs1Data != Rs2Data);
      BRU_LT:  res_taken = ($signed(Rs1Data) <  $signed(Rs2Data));
      BRU_GE:  res_taken = ($signed(Rs1Data) >= $signed(Rs2Data));
      BRU_LTU: res_taken = (Rs1Data <  Rs2Data);
      BRU_GEU: res_taken = (Rs1Data >= Rs2Data);
      BRU_JMP: res_taken = 1'b1;
      default: op_valid  = 1'b0;
    endcase
  end

  assign op_is_jmp   = (BRUOp == BRU_JMP);
  assign act         = ResValid && !Flush;
  // A resolve that coincides with reset must leave the tables untouched.
  assign train       = act && op_valid && !rst;
  assign seq_pc      = Pc + XLEN'(4);
  assign target_pc   = IsJalr ? ((Rs1Data + Imm) & ~XLEN'(1)) : (Pc + Imm);
  assign actual_pc   = res_taken ? target_pc : seq_pc;
  assign res_mispred = (actual_pc != PredPcIn);

  // ------------------------------------------------------- BHT training
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= BHT_WNT;
      end
    end else if (train && !op_is_jmp) begin
      ctr_q[res_bht_idx] <= ctr_next(ctr_q[res_bht_idx], res_taken);
    end
  end

  // ------------------------------------------------------ output register
  always_comb begin
    out_valid_d = act;
    taken_d     = 1'b0;
    mispred_d   = 1'b0;
    redirect_d  = redirect_q;
    if (act) begin
      taken_d    = res_taken;
      redirect_d = actual_pc;
      mispred_d  = res_mispred;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      redirect_q  <= '0;
      mispred_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      redirect_q  <= redirect_d;
      mispred_q   <= mispred_d;
    end
  end

  assign OutValid    = out_valid_q;
  assign BranchTaken = taken_q;
  assign RedirectPc  = redirect_q;
  assign Mispredict  = mispred_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (train) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (res_mispred) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_bru_predictor.sv
// Self-checking bench for bru_predictor: directed vector table, a reset
// corner sequence, then randomized traffic against a behavioural model.
module tb_bru_predictor;

  localparam int BHT = 64;
  localparam int BTB = 16;

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] FetchPc;
  logic        PredTaken;
  logic [31:0] PredPc;
  logic        ResValid;
  logic        Flush;
  logic [2:0]  BRUOp;
  logic        IsJalr;
  logic [31:0] Rs1Data, Rs2Data, Pc, Imm, PredPcIn;
  logic        OutValid;
  logic        BranchTaken;
  logic [31:0] RedirectPc;
  logic        Mispredict;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;
`endif

  int n_vec = 0;
  int n_mis = 0;

  bru_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .FetchPc     (FetchPc),
    .PredTaken   (PredTaken),
    .PredPc      (PredPc),
    .ResValid    (ResValid),
    .Flush       (Flush),
    .BRUOp       (BRUOp),
    .IsJalr      (IsJalr),
    .Rs1Data     (Rs1Data),
    .Rs2Data     (Rs2Data),
    .Pc          (Pc),
    .Imm         (Imm),
    .PredPcIn    (PredPcIn),
    .OutValid    (OutValid),
    .BranchTaken (BranchTaken),
    .RedirectPc  (RedirectPc),
`ifdef BRU_PERF_CNT_EN
    .BranchCount (BranchCount),
    .MispredCount(MispredCount),
`endif
    .Mispredict  (Mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] fetch;
    logic        rv, fl;
    logic [2:0]  op;
    logic        jalr;
    logic [31:0] rs1, rs2, pc, imm, ppin;
    logic        e_pt;
    logic [31:0] e_pp;
    logic        e_ov, e_bt;
    logic [31:0] e_rp;
    logic        e_mp;
  } vec_t;

  function automatic vec_t row(logic [31:0] fetch, logic rv, logic fl, logic [2:0] op, logic jalr,
                               logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc, logic [31:0] imm,
                               logic [31:0] ppin, logic pt, logic [31:0] pp, logic ov, logic bt,
                               logic [31:0] rp, logic mp);
    vec_t v;
    v.fetch = fetch; v.rv = rv; v.fl = fl; v.op = op; v.jalr = jalr;
    v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.ppin = ppin;
    v.e_pt = pt; v.e_pp = pp; v.e_ov = ov; v.e_bt = bt; v.e_rp = rp; v.e_mp = mp;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] fetch, logic pt, logic [31:0] pp, logic [31:0] rp);
    return row(fetch, 1'b0, 1'b0, OP_EQ, 1'b0, 0, 0, 0, 0, 0, pt, pp, 1'b0, 1'b0, rp, 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    FetchPc = v.fetch; ResValid = v.rv; Flush = v.fl; BRUOp = v.op; IsJalr = v.jalr;
    Rs1Data = v.rs1; Rs2Data = v.rs2; Pc = v.pc; Imm = v.imm; PredPcIn = v.ppin;
  endtask

  // ------------------------------------------------ behavioural reference
  int          m_ctr [BHT];
  bit          m_v   [BTB];
  logic [31:0] m_pc  [BTB];
  logic [31:0] m_tgt [BTB];
  bit          m_j   [BTB];
  logic        m_ov, m_bt, m_mp;
  logic [31:0] m_rp;
  logic [31:0] m_bcnt, m_mcnt;

  task automatic model_reset();
    for (int i = 0; i < BHT; i++) m_ctr[i] = 1;
    for (int i = 0; i < BTB; i++) m_v[i] = 0;
    m_ov = 0; m_bt = 0; m_mp = 0; m_rp = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  function automatic logic [31:0] model_pred(input logic [31:0] fpc, output logic pt);
    int  bi, ti;
    bit  hit;
    bi  = int'((fpc / 4) % BHT);
    ti  = int'((fpc / 4) % BTB);
    hit = m_v[ti] && ((m_pc[ti] / (4 * BTB)) == (fpc / (4 * BTB)));
    pt  = hit && (m_j[ti] || m_ctr[bi] >= 2);
    return pt ? m_tgt[ti] : fpc + 32'd4;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = 32'($urandom_range(0, 255)) << 2;
    p = p | (32'($urandom_range(0, 3)) << 12);
    return p;
  endfunction

  vec_t vecs [$];
  vec_t v;
  logic [31:0] exp_b, exp_m;

  initial begin
    rst = 1'b1;
    drive(idle(32'h100, 0, 0, 0));
    exp_b = 0; exp_m = 0;

    // Rows are one cycle each; lookup is checked before the edge,
    // registered results just after it.
    vecs.push_back(idle(32'h100, 0, 32'h104, 0));
    vecs.push_back(row(32'h100, 1, 0, OP_EQ, 0, 5, 5, 32'h100, 32'h40, 32'h104, 0, 32'h104, 1, 1, 32'h140, 1));
    vecs.push_back(idle(32'h100, 1, 32'h140, 32'h140));
    for (int i = 0; i < 4; i++)
      vecs.push_back(row(32'h100, 1, 0, OP_EQ, 0, 5, 5, 32'h100, 32'h40, 32'h140, 1, 32'h140, 1, 1, 32'h140, 0));
    vecs.push_back(row(32'h100, 1, 0, OP_EQ, 0, 5, 6, 32'h100, 32'h40, 32'h140, 1, 32'h140, 1, 0, 32'h104, 1));
    vecs.push_back(idle(32'h100, 1, 32'h140, 32'h104));
    vecs.push_back(row(32'h100, 1, 0, OP_EQ, 0, 5, 6, 32'h100, 32'h40, 32'h140, 1, 32'h140, 1, 0, 32'h104, 1));
    vecs.push_back(idle(32'h100, 0, 32'h104, 32'h104));
    vecs.push_back(row(32'h200, 1, 0, OP_JMP, 1, 32'h1001, 0, 32'h200, 4, 32'h204, 0, 32'h204, 1, 1, 32'h1004, 1));
    vecs.push_back(row(32'h200, 1, 0, OP_JMP, 1, 32'h1001, 0, 32'h200, 4, 32'h1004, 1, 32'h1004, 1, 1, 32'h1004, 0));
    vecs.push_back(idle(32'h100, 0, 32'h104, 32'h1004));
    vecs.push_back(row(32'h200, 1, 1, OP_EQ, 0, 7, 7, 32'h300, 32'h10, 32'h304, 1, 32'h1004, 0, 0, 32'h1004, 0));
    vecs.push_back(idle(32'h300, 0, 32'h304, 32'h1004));
    vecs.push_back(idle(32'h200, 1, 32'h1004, 32'h1004));
    vecs.push_back(row(32'h140, 1, 0, OP_JMP, 0, 0, 0, 32'h100, 32'h20, 32'h104, 0, 32'h144, 1, 1, 32'h120, 1));
    vecs.push_back(idle(32'h140, 0, 32'h144, 32'h120));
    vecs.push_back(idle(32'h100, 1, 32'h120, 32'h120));
    vecs.push_back(row(32'h100, 1, 0, OP_LT, 0, 32'hFFFF_FFFF, 1, 32'h400, 8, 32'h404, 1, 32'h120, 1, 1, 32'h408, 1));
    vecs.push_back(row(32'h400, 1, 0, OP_LTU, 0, 32'hFFFF_FFFF, 1, 32'h400, 8, 32'h404, 1, 32'h408, 1, 0, 32'h404, 0));
    vecs.push_back(idle(32'h400, 0, 32'h404, 32'h404));
    vecs.push_back(row(32'h400, 1, 0, OP_BAD, 0, 5, 5, 32'h400, 8, 32'h404, 0, 32'h404, 1, 0, 32'h404, 0));
    vecs.push_back(idle(32'h400, 0, 32'h404, 32'h404));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      @(negedge clk);
      check($sformatf("row%0d PredTaken", i), PredTaken, v.e_pt);
      check($sformatf("row%0d PredPc", i), PredPc, v.e_pp);
      @(posedge clk); #1;
      check($sformatf("row%0d OutValid", i), OutValid, v.e_ov);
      check($sformatf("row%0d BranchTaken", i), BranchTaken, v.e_bt);
      check($sformatf("row%0d RedirectPc", i), RedirectPc, v.e_rp);
      check($sformatf("row%0d Mispredict", i), Mispredict, v.e_mp);
      if (v.rv && !v.fl && v.op != OP_BAD) begin
        exp_b++;
        if (v.e_mp) exp_m++;
      end
`ifdef BRU_PERF_CNT_EN
      check($sformatf("row%0d BranchCount", i), BranchCount, exp_b);
      check($sformatf("row%0d MispredCount", i), MispredCount, exp_m);
`endif
    end

    // Resolve arriving together with reset is dropped.
    rst = 1'b1;
    drive(row(32'h100, 1, 0, OP_EQ, 0, 5, 5, 32'h100, 32'h40, 32'h104, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("rst_inflight OutValid", OutValid, 1'b0);
    check("rst_inflight RedirectPc", RedirectPc, 32'h0);
    check("rst_inflight Mispredict", Mispredict, 1'b0);
    rst = 1'b0;
    drive(idle(32'h100, 0, 0, 0));
    @(negedge clk);
    check("post_rst PredTaken", PredTaken, 1'b0);
    check("post_rst PredPc", PredPc, 32'h104);
    @(posedge clk); #1;
    check("post_rst OutValid", OutValid, 1'b0);
`ifdef BRU_PERF_CNT_EN
    check("post_rst BranchCount", BranchCount, 32'h0);
`endif

    // Randomized traffic against the reference model.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        pt_exp, tk, val, act;
      logic [31:0] pp_exp, tgt, actual, ppred;
      logic        dummy;
      int          bi, ti;

      rst      = ($urandom_range(0, 199) == 0);
      FetchPc  = pick_pc();
      ResValid = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 9) == 0);
      BRUOp    = 3'($urandom_range(0, 7));
      IsJalr   = (BRUOp == OP_JMP) && $urandom_range(0, 1);
      Rs1Data  = pick_val();
      Rs2Data  = ($urandom_range(0, 2) == 0) ? Rs1Data : pick_val();
      Pc       = pick_pc();
      Imm      = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2) - 32'h80;
      ppred    = model_pred(Pc, dummy);
      PredPcIn = $urandom_range(0, 1) ? ppred : (($urandom_range(0, 1) != 0) ? Pc + 32'd4 : $urandom);

      @(negedge clk);
      pp_exp = model_pred(FetchPc, pt_exp);
      check($sformatf("rnd%0d PredTaken", c), PredTaken, pt_exp);
      check($sformatf("rnd%0d PredPc", c), PredPc, pp_exp);

      val = 1'b1;
      case (BRUOp)
        OP_EQ:  tk = (Rs1Data == Rs2Data);
        OP_NE:  tk = (Rs1Data != Rs2Data);
        OP_LT:  tk = ($signed(Rs1Data) < $signed(Rs2Data));
        OP_GE:  tk = ($signed(Rs1Data) >= $signed(Rs2Data));
        OP_LTU: tk = (Rs1Data < Rs2Data);
        OP_GEU: tk = (Rs1Data >= Rs2Data);
        OP_JMP: tk = 1'b1;
        default: begin tk = 1'b0; val = 1'b0; end
      endcase
      tgt    = IsJalr ? ((Rs1Data + Imm) & 32'hFFFF_FFFE) : Pc + Imm;
      actual = tk ? tgt : Pc + 32'd4;
      act    = ResValid && !Flush;

      @(posedge clk); #1;
      if (rst) begin
        model_reset();
      end else begin
        m_ov = act;
        m_bt = act && tk;
        m_mp = act && (actual != PredPcIn);
        if (act) m_rp = actual;
        if (act && val) begin
          bi = int'((Pc / 4) % BHT);
          ti = int'((Pc / 4) % BTB);
          m_bcnt++;
          if (actual != PredPcIn) m_mcnt++;
          if (BRUOp != OP_JMP) m_ctr[bi] = tk ? ((m_ctr[bi] < 3) ? m_ctr[bi] + 1 : 3)
                                              : ((m_ctr[bi] > 0) ? m_ctr[bi] - 1 : 0);
          if (tk) begin
            m_v[ti] = 1; m_pc[ti] = Pc; m_tgt[ti] = tgt; m_j[ti] = (BRUOp == OP_JMP);
          end
        end
      end
      check($sformatf("rnd%0d OutValid", c), OutValid, m_ov);
      check($sformatf("rnd%0d BranchTaken", c), BranchTaken, m_bt);
      check($sformatf("rnd%0d RedirectPc", c), RedirectPc, m_rp);
      check($sformatf("rnd%0d Mispredict", c), Mispredict, m_mp);
`ifdef BRU_PERF_CNT_EN
      check($sformatf("rnd%0d BranchCount", c), BranchCount, m_bcnt);
      check($sformatf("rnd%0d MispredCount", c), MispredCount, m_mcnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
